fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the control decoder. It owns the PC, requests instructions from instruction memory over a req/ready handshake, and holds each fetched word stable for decode, which slices opcode/funct from it. It also applies redirects from the resolve stage: taken branch, J/JAL, and JR. It exports PC+4 for the JAL link write.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_next_pc_sel.sv | 33 +++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StHold  = 2'd2,
    StFlush = 2'd3
  } fetch_state_e;

  localparam logic [31:0] MipsNop = 32'h0000_0000;

  // Word offset is sign-extended and scaled to bytes; the sum wraps at 2^32.
  function automatic logic [31:0] branch_target(logic [31:0] pc4, logic [15:0] imm);
    return pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Redirect target selection: jr beats jump beats taken branch.
module next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] redir_pc4,
  input  logic [15:0] imm16,
  input  logic [25:0] jidx,
  input  logic [31:0] jr_target,
  input  logic        br_taken,
  input  logic        jump,
  input  logic        jr,
  output logic [31:0] next_pc,
  output logic        redirect
);

  logic [1:0] unused_jr_bits;
  assign unused_jr_bits = jr_target[1:0];

  assign redirect = br_taken | jump | jr;

  always_comb begin
    next_pc = pc;
    if (jr) begin
      next_pc = {jr_target[31:2], 2'b00};
    end else if (jump) begin
      next_pc = {redir_pc4[31:28], jidx, 2'b00};
    end else if (br_taken) begin
      next_pc = branch_target(redir_pc4, imm16);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches over req/ready, holds the word for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        dec_ready,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] redir_pc4,
  input  logic [15:0] imm16,
  input  logic [25:0] jidx,
  input  logic [31:0] jr_target
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         valid_q, valid_d;

  logic [31:0]  sel_pc;
  logic         redirect;
  logic         accept;
  logic [31:0]  pc_inc;

  next_pc_sel u_next_pc_sel (
    .pc        (pc_q),
    .redir_pc4 (redir_pc4),
    .imm16     (imm16),
    .jidx      (jidx),
    .jr_target (jr_target),
    .br_taken  (br_taken),
    .jump      (jump),
    .jr        (jr),
    .next_pc   (sel_pc),
    .redirect  (redirect)
  );

  assign accept = valid_q && dec_ready && !stall;
  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    unique case (state_q)
      StIdle: begin
        pc_d       = sel_pc;
        req_addr_d = sel_pc;
        state_d    = StReq;
      end
      StReq: begin
        if (redirect) begin
          pc_d = sel_pc;
          // An issued request must finish at its original address before retargeting.
          if (imem_ready) begin
            req_addr_d = sel_pc;
          end else begin
            state_d = StFlush;
          end
        end else if (imem_ready) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d       = sel_pc;
          req_addr_d = sel_pc;
          valid_d    = 1'b0;
          state_d    = StReq;
        end else if (accept) begin
          pc_d       = pc_inc;
          req_addr_d = pc_inc;
          valid_d    = 1'b0;
          state_d    = StReq;
        end
      end
      StFlush: begin
        pc_d = sel_pc;
        if (imem_ready) begin
          req_addr_d = sel_pc;
          state_d    = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= MipsNop;
      pc_out_q   <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_req    = (state_q == StReq) || (state_q == StFlush);
  assign imem_addr   = req_addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_out_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus reset/wrap sequences.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        dec_ready;
  logic        stall;
  logic        br_taken;
  logic        jump;
  logic        jr;
  logic [31:0] redir_pc4;
  logic [15:0] imm16;
  logic [25:0] jidx;
  logic [31:0] jr_target;

  int unsigned n_checks;
  int unsigned n_pass;

  typedef struct {
    logic        rdy;
    logic        dec;
    logic        stl;
    logic        br;
    logic        jmp;
    logic        jrr;
    logic [31:0] pc4;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] jrt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_po;
  } vec_t;

  vec_t vecs[$];

  fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .dec_ready   (dec_ready),
    .stall       (stall),
    .br_taken    (br_taken),
    .jump        (jump),
    .jr          (jr),
    .redir_pc4   (redir_pc4),
    .imm16       (imm16),
    .jidx        (jidx),
    .jr_target   (jr_target)
  );

  // Memory returns a word that encodes its own address.
  assign imem_rdata = {16'hDEAD, imem_addr[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    imem_ready = v.rdy;
    dec_ready  = v.dec;
    stall      = v.stl;
    br_taken   = v.br;
    jump       = v.jmp;
    jr         = v.jrr;
    redir_pc4  = v.pc4;
    imm16      = v.imm;
    jidx       = v.idx;
    jr_target  = v.jrt;
  endtask

  task automatic idle_inputs();
    imem_ready = 1'b0;
    dec_ready  = 1'b0;
    stall      = 1'b0;
    br_taken   = 1'b0;
    jump       = 1'b0;
    jr         = 1'b0;
    redir_pc4  = '0;
    imm16      = '0;
    jidx       = '0;
    jr_target  = '0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    idle_inputs();

    //          rdy dec stl br jmp jr  pc4           imm       idx       jrt           req addr          vld instr         pc_out
    vecs.push_back('{1, 1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        1, 32'h0,        0, 32'h0,         32'h0});
    vecs.push_back('{0, 1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        0, 32'h0,        1, 32'hDEAD0000,  32'h0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        1, 32'h4,        0, 32'hDEAD0000,  32'h0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        1, 32'h4,        0, 32'hDEAD0000,  32'h0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        1, 32'h4,        0, 32'hDEAD0000,  32'h0});
    vecs.push_back('{1, 1, 1, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        0, 32'h4,        1, 32'hDEAD0004,  32'h4});
    vecs.push_back('{1, 1, 1, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        0, 32'h4,        1, 32'hDEAD0004,  32'h4});
    vecs.push_back('{1, 1, 1, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        0, 32'h4,        1, 32'hDEAD0004,  32'h4});
    vecs.push_back('{1, 1, 1, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        0, 32'h4,        1, 32'hDEAD0004,  32'h4});
    vecs.push_back('{1, 1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        0, 32'h4,        1, 32'hDEAD0004,  32'h4});
    vecs.push_back('{1, 1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        1, 32'h8,        0, 32'hDEAD0004,  32'h4});
    vecs.push_back('{0, 1, 0, 1, 0, 0, 32'h100,      16'hFFFE, 26'h0,    32'h0,        0, 32'h8,        1, 32'hDEAD0008,  32'h8});
    vecs.push_back('{1, 1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        1, 32'hF8,       0, 32'hDEAD0008,  32'h8});
    vecs.push_back('{0, 1, 0, 0, 1, 1, 32'h100,      16'h0,    26'h40,   32'h2003,     0, 32'hF8,       1, 32'hDEAD00F8,  32'hF8});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 32'h0,        16'h0,    26'h100,  32'h0,        1, 32'h2000,     0, 32'hDEAD00F8,  32'hF8});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        1, 32'h2000,     0, 32'hDEAD00F8,  32'hF8});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        1, 32'h2000,     0, 32'hDEAD00F8,  32'hF8});
    vecs.push_back('{1, 1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        1, 32'h400,      0, 32'hDEAD00F8,  32'hF8});
    vecs.push_back('{0, 1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        0, 32'h400,      1, 32'hDEAD0400,  32'h400});
    vecs.push_back('{1, 0, 0, 1, 0, 0, 32'h500,      16'h0004, 26'h0,    32'h0,        1, 32'h404,      0, 32'hDEAD0400,  32'h400});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 32'hF000_0000, 16'h0,   26'h1,    32'h0,        1, 32'h510,      0, 32'hDEAD0400,  32'h400});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,    32'h3000,     1, 32'h510,      0, 32'hDEAD0400,  32'h400});
    vecs.push_back('{1, 0, 0, 1, 0, 0, 32'h8,        16'h0001, 26'h0,    32'h0,        1, 32'h510,      0, 32'hDEAD0400,  32'h400});
    vecs.push_back('{1, 1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        1, 32'hC,        0, 32'hDEAD0400,  32'h400});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,    32'h0,        0, 32'hC,        1, 32'hDEAD000C,  32'hC});

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req",   {31'b0, imem_req},    32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr,                32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      check($sformatf("v%0d_req", i),   {31'b0, imem_req},    {31'b0, vecs[i].e_req});
      check($sformatf("v%0d_addr", i),  imem_addr,            vecs[i].e_addr);
      check($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d_instr", i), instr,                vecs[i].e_instr);
      check($sformatf("v%0d_pc_out", i), pc_out,              vecs[i].e_po);
      check($sformatf("v%0d_pc4", i),   pc_plus4,             vecs[i].e_po + 32'd4);
      drive(vecs[i]);
    end

    // Reset while flushing: outstanding request is abandoned.
    @(negedge clk);
    idle_inputs();
    dec_ready = 1'b1;
    @(negedge clk);
    check("pre_flush_addr", imem_addr, 32'h10);
    idle_inputs();
    jump = 1'b1;
    jidx = 26'h5;
    @(negedge clk);
    check("flush_req",  {31'b0, imem_req}, 32'h1);
    check("flush_addr", imem_addr,         32'h10);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_req",    {31'b0, imem_req},    32'h0);
    check("mid_rst_valid",  {31'b0, instr_valid}, 32'h0);
    check("mid_rst_instr",  instr,                32'h0);
    check("mid_rst_addr",   imem_addr,            32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req",  {31'b0, imem_req}, 32'h1);
    check("post_rst_addr", imem_addr,         32'h0);

    // JR to the top word, then check pc_plus4 wraps to zero.
    jr        = 1'b1;
    jr_target = 32'hFFFF_FFFF;
    @(negedge clk);
    idle_inputs();
    imem_ready = 1'b1;
    @(negedge clk);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_valid",  {31'b0, instr_valid}, 32'h1);
    check("wrap_instr",  instr,                32'hDEAD_FFFC);
    check("wrap_pc_out", pc_out,               32'hFFFF_FFFC);
    check("wrap_pc4",    pc_plus4,             32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
